// File: rtl/hfswr_clk_pkg.sv
// Shared definitions for the clock/PLL supervision logic.
//   sup_state_e : supervisor state encoding, also driven on state_o
//   LOST_CNT_W  : width of the saturating lock-loss counter
package hfswr_clk_pkg;

   typedef enum logic [2:0] {
      PLL_RST   = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      RUN       = 3'd3,
      FAIL      = 3'd4
   } sup_state_e;

   localparam int LOST_CNT_W = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous status inputs, with asynchronous
// active-low clear. Output lags input by two clk_i edges.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low clear of both flop stages
//   d_i    : asynchronous input bits
//   q_o    : synchronized output bits
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/pll_supervisor.sv
// PLL supervisor: sequences PLL reset, lock acquisition and a lock-stability
// wait before releasing the system reset; re-arms the PLL on lock loss and
// parks in FAIL after MAX_RETRY consecutive acquisition timeouts.
// Runs on the PLL reference clock.
//   clk             : reference clock
//   rstn            : asynchronous active-low reset
//   pll_locked      : PLL LOCKED, asynchronous, synchronized internally
//   retry_i         : single-cycle pulse, leaves FAIL
//   pll_rstn_o      : active-low PLL reset
//   sys_rstn_o      : active-low system reset, high only in RUN
//   fail_o          : high in FAIL
//   state_o         : current state encoding
//   lock_lost_cnt_o : saturating count of lock losses seen in RUN
module pll_supervisor
   import hfswr_clk_pkg::*;
#(
   parameter int unsigned PLL_RST_CYC = 16,
   parameter int unsigned LOCK_WAIT   = 12500,
   parameter int unsigned STABLE_CNT  = 1024,
   parameter int unsigned MAX_RETRY   = 3
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  pll_locked,
   input  logic                  retry_i,
   output logic                  pll_rstn_o,
   output logic                  sys_rstn_o,
   output logic                  fail_o,
   output logic [2:0]            state_o,
   output logic [LOST_CNT_W-1:0] lock_lost_cnt_o
);

   localparam int unsigned MAX_AB  = (PLL_RST_CYC > LOCK_WAIT) ? PLL_RST_CYC : LOCK_WAIT;
   localparam int unsigned CNT_MAX = (MAX_AB > STABLE_CNT) ? MAX_AB : STABLE_CNT;
   localparam int          CNT_W   = $clog2(CNT_MAX + 1);
   localparam int          RTY_W   = $clog2(MAX_RETRY + 1);

   localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(PLL_RST_CYC - 1);
   localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_WAIT - 1);
   localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(STABLE_CNT - 1);
   localparam logic [RTY_W-1:0] RTY_LAST  = RTY_W'(MAX_RETRY - 1);

   sup_state_e            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [RTY_W-1:0]      rty_q, rty_d;
   logic [LOST_CNT_W-1:0] lost_q, lost_d;
   logic                  pll_rstn_q, pll_rstn_d;
   logic                  sys_rstn_q, sys_rstn_d;
   logic                  fail_q, fail_d;
   logic                  locked_s;

   sync_2ff #(.WIDTH(1)) u_lock_sync (
      .clk_i  (clk),
      .rst_ni (rstn),
      .d_i    (pll_locked),
      .q_o    (locked_s)
   );

   always_comb begin
      state_d = state_q;
      rty_d   = rty_q;
      lost_d  = lost_q;
      unique case (state_q)
         PLL_RST: begin
            if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
         end
         WAIT_LOCK: begin
            // lock seen in the timeout cycle still wins
            if (locked_s) begin
               state_d = STABLE;
            end else if (cnt_q == LOCK_LAST) begin
               if (rty_q == RTY_LAST) begin
                  state_d = FAIL;
               end else begin
                  rty_d   = rty_q + 1'b1;
                  state_d = PLL_RST;
               end
            end
         end
         STABLE: begin
            // a dropout here is treated as instability, not a timeout
            if (!locked_s) begin
               state_d = WAIT_LOCK;
            end else if (cnt_q == STAB_LAST) begin
               state_d = RUN;
               rty_d   = '0;
            end
         end
         RUN: begin
            if (!locked_s) begin
               state_d = PLL_RST;
               if (lost_q != '1) lost_d = lost_q + 1'b1;
            end
         end
         FAIL: begin
            if (retry_i) begin
               state_d = PLL_RST;
               rty_d   = '0;
            end
         end
         default: state_d = PLL_RST;
      endcase

      // counter restarts on every transition and idles in RUN/FAIL
      if (state_d != state_q || state_q == RUN || state_q == FAIL) cnt_d = '0;
      else                                                          cnt_d = cnt_q + 1'b1;

      // outputs decoded from the next state so they move on the same edge
      pll_rstn_d = !(state_d == PLL_RST || state_d == FAIL);
      sys_rstn_d = (state_d == RUN);
      fail_d     = (state_d == FAIL);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= PLL_RST;
         cnt_q      <= '0;
         rty_q      <= '0;
         lost_q     <= '0;
         pll_rstn_q <= 1'b0;
         sys_rstn_q <= 1'b0;
         fail_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rty_q      <= rty_d;
         lost_q     <= lost_d;
         pll_rstn_q <= pll_rstn_d;
         sys_rstn_q <= sys_rstn_d;
         fail_q     <= fail_d;
      end
   end

   assign pll_rstn_o      = pll_rstn_q;
   assign sys_rstn_o      = sys_rstn_q;
   assign fail_o          = fail_q;
   assign state_o         = state_q;
   assign lock_lost_cnt_o = lost_q;

endmodule

// File: doc/pll_supervisor.md
Name: pll_supervisor

Overview:
- Consumes the PLL's lock status and drives the PLL's active-low reset and the transmitter's synchronous system reset.
- Sequences PLL reset, lock acquisition and a lock-stability wait, then releases the system reset.
- On loss of lock it re-arms the PLL. After repeated acquisition timeouts it parks in a FAIL state until software requests a retry.
- Runs on the reference input clock, i.e. the same clock that feeds the PLL, not a PLL output.

Parameters:
- PLL_RST_CYC, 16, cycles pll_rstn_o is held low per PLL reset pulse (>=1).
- LOCK_WAIT, 12500, cycles allowed in WAIT_LOCK before timeout (>=1).
- STABLE_CNT, 1024, consecutive synchronized-locked cycles required before system reset release (>=1).
- MAX_RETRY, 3, consecutive WAIT_LOCK timeouts before entering FAIL (>=1).

Ports:
- clk  in  1  reference clock.
- rstn  in  1  reset. Asynchronous, active-low.
- pll_locked  in  1  PLL LOCKED. Asynchronous to clk; internally 2-FF synchronized to locked_s.
- retry_i  in  1  single-cycle pulse; restarts the sequence from FAIL.
- pll_rstn_o  out  1  active-low PLL reset; feeds the PLL rstn.
- sys_rstn_o  out  1  active-low system reset for downstream logic; registered.
- fail_o  out  1  high while in FAIL.
- state_o  out  3  current state encoding.
- lock_lost_cnt_o  out  8  count of lock losses in RUN; saturates at 255.

Behaviour:
- Reset (rstn low, asynchronous):
  - state=PLL_RST, pll_rstn_o=0, sys_rstn_o=0, fail_o=0, lock_lost_cnt_o=0.
  - Cycle counter, retry counter and synchronizer flops cleared.
  - Reset asserted mid-operation aborts immediately to these values.
- Sync: locked_s = pll_locked delayed through 2 flops (2-cycle latency). Every decision below uses locked_s only.
- All outputs are registered and decoded from the state register.
  - pll_rstn_o=0 in PLL_RST and FAIL, else 1.
  - sys_rstn_o=1 only in RUN.
  - fail_o=1 only in FAIL.
- Counter width is $clog2(max(PLL_RST_CYC, LOCK_WAIT, STABLE_CNT)+1). The counter clears on every state transition.
- Encoding (state_o): PLL_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4.
- PLL_RST: after PLL_RST_CYC cycles (cnt==PLL_RST_CYC-1) go to WAIT_LOCK.
- WAIT_LOCK:
  - locked_s=1 -> STABLE. This takes priority over a timeout in the same cycle.
  - Else at cnt==LOCK_WAIT-1, i.e. timeout:
    - if retry_cnt==MAX_RETRY-1 -> FAIL;
    - else retry_cnt++ and go to PLL_RST.
- STABLE:
  - locked_s=0 -> WAIT_LOCK, with no retry increment.
  - At cnt==STABLE_CNT-1 with locked_s=1 -> RUN.
- RUN:
  - retry_cnt is cleared on entry.
  - locked_s=0 -> PLL_RST and lock_lost_cnt_o++ (held at 255 once reached). sys_rstn_o falls on the same edge the state leaves RUN.
- FAIL:
  - The PLL is held in reset.
  - retry_i=1 -> PLL_RST with retry_cnt=0.
  - retry_i is ignored in every other state.
- A glitch on pll_locked lasting at least one synchronized cycle counts as a drop. Shorter glitches may be filtered by the synchronizer; no further filtering is done.
- Startup latency with pll_locked already high: sys_rstn_o rises PLL_RST_CYC+1+STABLE_CNT edges after the first clk edge with rstn high.

Decomposition:
- Package hfswr_clk_pkg holds:
  - the state enum / encoding constants (PLL_RST..FAIL);
  - a lock-loss counter width constant of 8.
- One sub-module, sync_2ff. It is a parameterizable-width 2-flop synchronizer with asynchronous active-low clear, reused for any other asynchronous status inputs.

Test Plan:
- Common parameters: PLL_RST_CYC=4, LOCK_WAIT=20, STABLE_CNT=8, MAX_RETRY=3.
- T1, nominal startup: pll_locked=1 throughout; release rstn -> pll_rstn_o rises at edge 4; sys_rstn_o rises at edge 13; state_o=3.
- T2, instability: pll_locked drops for 3 cycles while in STABLE -> state returns to 1, with no PLL reset pulse and retry count unchanged; after relock, RUN is reached 1+8 edges after locked_s returns high.
- T3, lock loss in RUN: pll_locked=0 -> 2 cycles later state=0, sys_rstn_o=0, lock_lost_cnt_o=1, and pll_rstn_o is low for 4 cycles; 300 such losses leave lock_lost_cnt_o=255.
- T4, exhaustion: pll_locked=0 forever -> three 20-cycle WAIT_LOCK windows, with a 4-cycle PLL reset pulse between them, then state=4, fail_o=1, pll_rstn_o=0; retry_i pulses during WAIT_LOCK are ignored.
- T5, retry from FAIL: in FAIL, assert pll_locked=1 and pulse retry_i -> fail_o=0 next edge, then normal startup to RUN.
- T6, asynchronous reset mid-operation: rstn low while in STABLE, asynchronous to clk -> all outputs reach reset values without a clock edge; lock_lost_cnt_o=0.
